// File: rtl/mem_dumper.sv
// mem_dumper: memory-port initiator that either streams a contiguous address
// range out over a valid/ready handshake (dump) or writes a constant word
// across a range (fill). Ranges are inclusive and wrap modulo 2^AW.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; inputs latched on accepted start
// ISSUE   | read address presented to memory
// CAPTURE | read data returning on mem_in; captured at the closing edge
// HOLD    | word offered on out_*, waiting for out_ready
// FILL    | writing fill word to cur every cycle
// FIN     | one-cycle done pulse, then back to IDLE
module mem_dumper #(
    parameter int AW = 6,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] last_addr,
    input  logic [DW-1:0] fill_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_HOLD    = 3'd3,
        S_FILL    = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cur;
    logic [AW-1:0] last;
    logic [DW-1:0] fill;
    logic          at_last;

    assign at_last = (cur == last);

    // State register; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = mode ? S_FILL : S_ISSUE;
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_HOLD;
            S_HOLD:    if (out_ready) state_nxt = at_last ? S_FIN : S_ISSUE;
            S_FILL:    if (at_last) state_nxt = S_FIN;
            S_FIN:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Range/operand latches, address walker and the registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            last      <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur  <= base_addr;
                        last <= last_addr;
                        fill <= fill_data;
                    end
                end
                S_CAPTURE: begin
                    out_data  <= mem_in;
                    out_addr  <= cur;
                    out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!at_last) cur <= cur + AW'(1);
                    end
                end
                S_FILL: begin
                    if (!at_last) cur <= cur + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Memory port and status outputs, decoded from state so mem_we falls
    // as soon as reset forces IDLE.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        busy     = (state != S_IDLE);
        done     = (state == S_FIN);
        case (state)
            S_ISSUE, S_CAPTURE: mem_addr = cur;
            S_FILL: begin
                mem_we   = 1'b1;
                mem_addr = cur;
                mem_data = fill;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_dumper.sv
// Directed bench for mem_dumper with a synchronous 64x16 memory model.
module tb_mem_dumper;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [5:0]  base_addr;
    logic [5:0]  last_addr;
    logic [15:0] fill_data;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_data;
    logic [15:0] mem_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [5:0]  out_addr;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:63];
    logic        preload;

    int checks;
    int failures;

    mem_dumper #(.AW(6), .DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .last_addr (last_addr),
        .fill_data (fill_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_in    (mem_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous read, write-enable port; preload pattern 1000+i.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h1000 + 16'(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
        mem_in <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Dump b..l (n words). Optional stall on one word, optional mid-run poke of
    // start/base/last/mode that must be ignored.
    task automatic dump_run(input logic [5:0] b, input logic [5:0] l, input int n,
                            input int stall_word, input int stall_cyc, input bit poke);
        logic [5:0]  a;
        logic [15:0] d;
        mode      = 1'b0;
        base_addr = b;
        last_addr = l;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w < n; w++) begin
            a = b + 6'(w);
            d = 16'h1000 + {10'd0, a};
            chk("issue_busy", {31'd0, busy}, 32'd1);
            chk("issue_valid", {31'd0, out_valid}, 32'd0);
            tick();
            tick();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {16'd0, out_data}, {16'd0, d});
            chk("hold_addr", {26'd0, out_addr}, {26'd0, a});
            chk("hold_we", {31'd0, mem_we}, 32'd0);
            chk("hold_done", {31'd0, done}, 32'd0);
            if (poke && w == 1) begin
                start     = 1'b1;
                mode      = 1'b1;
                base_addr = 6'd0;
                last_addr = 6'd0;
            end
            if (poke && w == 2) start = 1'b0;
            if (w == stall_word) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_cyc; s++) begin
                    tick();
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_data", {16'd0, out_data}, {16'd0, d});
                    chk("stall_addr", {26'd0, out_addr}, {26'd0, a});
                end
                out_ready = 1'b1;
            end
            tick();
            chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
            chk("post_hs_done", {31'd0, done}, (w == n - 1) ? 32'd1 : 32'd0);
        end
        chk("fin_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        start = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        preload   = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        base_addr = '0;
        last_addr = '0;
        fill_data = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_maddr", {26'd0, mem_addr}, 32'd0);
        chk("rst_mdata", {16'd0, mem_data}, 32'd0);
        chk("rst_odata", {16'd0, out_data}, 32'd0);
        chk("rst_oaddr", {26'd0, out_addr}, 32'd0);
        tick();
        tick();
        preload = 1'b0;
        rst_n   = 1'b1;
        tick();

        // 1: plain dump 4..7
        dump_run(6'd4, 6'd7, 4, -1, 0, 1'b0);
        // 2: same with a 5-cycle stall on word 5
        dump_run(6'd4, 6'd7, 4, 1, 5, 1'b0);

        // 3: fill 10..12 with BEEF
        mode      = 1'b1;
        base_addr = 6'd10;
        last_addr = 6'd12;
        fill_data = 16'hBEEF;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        fill_data = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            chk("fill_we", {31'd0, mem_we}, 32'd1);
            chk("fill_addr", {26'd0, mem_addr}, 32'(10 + k));
            chk("fill_data", {16'd0, mem_data}, 32'h0000BEEF);
            chk("fill_done", {31'd0, done}, 32'd0);
            tick();
        end
        chk("fill_fin_we", {31'd0, mem_we}, 32'd0);
        chk("fill_fin_done", {31'd0, done}, 32'd1);
        chk("fill_fin_mdata", {16'd0, mem_data}, 32'd0);
        tick();
        chk("fill_idle_busy", {31'd0, busy}, 32'd0);
        chk("mem10", {16'd0, mem[10]}, 32'h0000BEEF);
        chk("mem11", {16'd0, mem[11]}, 32'h0000BEEF);
        chk("mem12", {16'd0, mem[12]}, 32'h0000BEEF);
        chk("mem9", {16'd0, mem[9]}, 32'h00001009);
        chk("mem13", {16'd0, mem[13]}, 32'h0000100D);

        // 4: wrapping dump 62..1
        dump_run(6'd62, 6'd1, 4, -1, 0, 1'b0);
        // 5: start/base/mode poked mid-dump must be ignored
        dump_run(6'd4, 6'd7, 4, -1, 0, 1'b1);
        chk("poke_mem0", {16'd0, mem[0]}, 32'h00001000);

        // 6: reset during fill 16..40 at address 20
        mode      = 1'b1;
        base_addr = 6'd16;
        last_addr = 6'd40;
        fill_data = 16'hDEAD;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_addr", {26'd0, mem_addr}, 32'd20);
        chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_we", {31'd0, mem_we}, 32'd0);
        chk("abort_maddr", {26'd0, mem_addr}, 32'd0);
        chk("abort_mdata", {16'd0, mem_data}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_odata", {16'd0, out_data}, 32'd0);
        chk("abort_oaddr", {26'd0, out_addr}, 32'd0);
        tick();
        chk("abort_done2", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("after_busy", {31'd0, busy}, 32'd0);
        chk("after_done", {31'd0, done}, 32'd0);
        tick();
        chk("after_busy2", {31'd0, busy}, 32'd0);
        for (int i = 16; i < 20; i++) chk("mem_filled", {16'd0, mem[i]}, 32'h0000DEAD);
        for (int i = 20; i <= 40; i++) chk("mem_untouched", {16'd0, mem[i]}, 32'h1000 + 32'(i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
